// File: rtl/uca_pkg.sv
// rtl/uca_pkg.sv - shared types and literal helpers for the unit-clause arbiter
//
// Purpose: literal typedef, arbiter FSM state enum, null-literal constant and
//   helpers that split a two's-complement literal into variable index and polarity.
// Ports: none (package).
package uca_pkg;

  localparam int UCA_DEF_LIT_W = 9;
  localparam int NULL_LIT      = 0;

  typedef logic signed [UCA_DEF_LIT_W-1:0] lit_t;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_ARB   = 2'd1,
    S_CONFL = 2'd2
  } uca_state_e;

  // Callers sign-extend the literal to 32 bits first, so one helper serves any LIT_W.
  function automatic int lit_var(input int lit);
    return (lit < 0) ? -lit : lit;
  endfunction

  // 1 = negative polarity
  function automatic logic lit_pol(input int lit);
    return lit < 0;
  endfunction

endpackage

// File: rtl/uca_fifo.sv
// rtl/uca_fifo.sv - synchronous FIFO with flush for the unit-clause queue
//
// Purpose: DEPTH-entry (power of two) FIFO; flush empties it on the next edge and
//   wins over push/pop. Push while full is only legal with a pop in the same cycle.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               empty the FIFO
//   push, push_data     write one entry
//   pop                 drop the head entry
//   pop_data            head entry (valid when !empty)
//   full, empty         status
module uca_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  // One extra wrap bit distinguishes full from empty.
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    if (flush) begin
      wp_d = '0;
      rp_d = '0;
    end else begin
      if (push) begin
        mem_d[wp_q[AW-1:0]] = push_data;
        wp_d = wp_q + 1'b1;
      end
      if (pop) begin
        rp_d = rp_q + 1'b1;
      end
    end
  end

  assign empty    = (wp_q == rp_q);
  assign full     = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign pop_data = mem_q[rp_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
    end
  end

endmodule

// File: rtl/uc_arbiter_mc.sv
// rtl/uc_arbiter_mc.sv - multi-channel unit-clause arbiter with dedup and conflict detect
//
// Purpose: serves the clause-memory loader (S_LOAD), then NUM_ENGINE engines round-robin
//   (S_ARB). Each accepted literal is checked against a per-variable assignment table:
//   new -> recorded and pushed to the UCQ FIFO, same polarity -> dropped, opposite
//   polarity -> sticky conflict (S_CONFL) until clear or reset.
// Ports:
//   clk, rst (async, active-low), clear (sync soft clear)
//   mem_valid/mem_lit/mem_done/mem_ready   loader channel
//   eng_valid/eng_lit/eng_grant            engine channels, grant is one-hot
//   ucq_valid/ucq_lit/ucq_ready            UCQ FIFO head towards consumer
//   conflict/conflict_lit                  sticky conflict report
//   stat_push/stat_dup/stat_null           only when UCA_STATS_EN is defined
// Config macro: UCA_STATS_EN adds saturating 16-bit push/dup/null counters.
module uc_arbiter_mc
  import uca_pkg::*;
#(
  parameter int NUM_ENGINE = 4,
  parameter int NUM_VARS   = 255,
  parameter int LIT_W      = $clog2(NUM_VARS + 1) + 1,
  parameter int UCQ_SIZE   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        mem_valid,
  input  logic [LIT_W-1:0]            mem_lit,
  input  logic                        mem_done,
  output logic                        mem_ready,
  input  logic [NUM_ENGINE-1:0]       eng_valid,
  input  logic [NUM_ENGINE*LIT_W-1:0] eng_lit,
  output logic [NUM_ENGINE-1:0]       eng_grant,
  output logic                        ucq_valid,
  output logic [LIT_W-1:0]            ucq_lit,
  input  logic                        ucq_ready,
  output logic                        conflict,
  output logic [LIT_W-1:0]            conflict_lit
`ifdef UCA_STATS_EN
  ,
  output logic [15:0]                 stat_push,
  output logic [15:0]                 stat_dup,
  output logic [15:0]                 stat_null
`endif
);
  localparam int RR_W   = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;
  localparam int VIDX_W = LIT_W - 1;

  uca_state_e        state_q, state_d;
  logic [RR_W-1:0]   rr_q, rr_d;
  logic              conflict_q, conflict_d;
  logic [LIT_W-1:0]  conflict_lit_q, conflict_lit_d;
  logic [NUM_VARS:0] asg_q, asg_d, pol_q, pol_d;

  logic              fifo_full, fifo_empty, fifo_full_eff, fifo_pop, fifo_flush;
  logic [LIT_W-1:0]  fifo_head, sel_lit;
  logic              gnt_hit;
  logic [RR_W-1:0]   gnt_idx;
  logic              mem_acc, eng_acc, accept;
  int                lit_i, lit_v;
  logic              lit_p, lit_null;
  logic [VIDX_W-1:0] vidx;
  logic              do_push, do_dup, do_confl;

  // First requester at or after rr_q, wrapping.
  always_comb begin
    gnt_hit = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_ENGINE; k++) begin
      if (!gnt_hit && eng_valid[(int'(rr_q) + k) % NUM_ENGINE]) begin
        gnt_hit = 1'b1;
        gnt_idx = RR_W'((int'(rr_q) + k) % NUM_ENGINE);
      end
    end
  end

  // Output handshakes are gated by rst so every output reads 0 while reset is held.
  assign ucq_valid     = rst && !fifo_empty && (state_q != S_CONFL);
  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign fifo_full_eff = fifo_full && !(ucq_valid && ucq_ready);
  assign mem_ready     = rst && (state_q == S_LOAD) && !fifo_full_eff && !conflict_q;

  always_comb begin
    eng_grant = '0;
    if (rst && (state_q == S_ARB) && !fifo_full_eff && gnt_hit) eng_grant[gnt_idx] = 1'b1;
  end

  assign mem_acc  = mem_valid && mem_ready;
  assign eng_acc  = |eng_grant;
  assign accept   = (mem_acc || eng_acc) && !clear;
  assign sel_lit  = mem_acc ? mem_lit : eng_lit[int'(gnt_idx)*LIT_W +: LIT_W];
  assign lit_i    = int'($signed(sel_lit));
  assign lit_v    = lit_var(lit_i);
  assign lit_p    = lit_pol(lit_i);
  // The most negative literal has magnitude 2^(LIT_W-1) > NUM_VARS, so the range test covers it.
  assign lit_null = (lit_v == NULL_LIT) || (lit_v > NUM_VARS);
  assign vidx     = lit_v[VIDX_W-1:0];
  assign do_push  = accept && !lit_null && !asg_q[vidx];
  assign do_dup   = accept && !lit_null && asg_q[vidx] && (pol_q[vidx] == lit_p);
  assign do_confl = accept && !lit_null && asg_q[vidx] && (pol_q[vidx] != lit_p);

  assign fifo_pop   = ucq_valid && ucq_ready && !clear;
  assign fifo_flush = clear || do_confl;

  uca_fifo #(
    .DEPTH(UCQ_SIZE),
    .WIDTH(LIT_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst),
    .flush    (fifo_flush),
    .push     (do_push),
    .push_data(sel_lit),
    .pop      (fifo_pop),
    .pop_data (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign ucq_lit      = fifo_head;
  assign conflict     = conflict_q;
  assign conflict_lit = conflict_lit_q;

`ifdef UCA_STATS_EN
  logic [15:0] st_push_q, st_push_d, st_dup_q, st_dup_d, st_null_q, st_null_d;
  assign stat_push = st_push_q;
  assign stat_dup  = st_dup_q;
  assign stat_null = st_null_q;
`endif

  always_comb begin
    state_d        = state_q;
    rr_d           = rr_q;
    conflict_d     = conflict_q;
    conflict_lit_d = conflict_lit_q;
    asg_d          = asg_q;
    pol_d          = pol_q;
`ifdef UCA_STATS_EN
    st_push_d = st_push_q;
    st_dup_d  = st_dup_q;
    st_null_d = st_null_q;
`endif
    if (clear) begin
      state_d        = S_LOAD;
      rr_d           = '0;
      conflict_d     = 1'b0;
      conflict_lit_d = '0;
      asg_d          = '0;
      pol_d          = '0;
`ifdef UCA_STATS_EN
      st_push_d = '0;
      st_dup_d  = '0;
      st_null_d = '0;
`endif
    end else begin
      if (eng_acc) rr_d = (int'(gnt_idx) == NUM_ENGINE - 1) ? '0 : gnt_idx + 1'b1;
      if (do_push) begin
        asg_d[vidx] = 1'b1;
        pol_d[vidx] = lit_p;
      end
      if (do_confl) begin
        conflict_d     = 1'b1;
        conflict_lit_d = sel_lit;
        state_d        = S_CONFL;
      end else if ((state_q == S_LOAD) && mem_done) begin
        state_d = S_ARB;
      end
`ifdef UCA_STATS_EN
      if (do_push && st_push_q != 16'hFFFF) st_push_d = st_push_q + 16'd1;
      if (do_dup && st_dup_q != 16'hFFFF) st_dup_d = st_dup_q + 16'd1;
      if (accept && lit_null && st_null_q != 16'hFFFF) st_null_d = st_null_q + 16'd1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_LOAD;
      rr_q           <= '0;
      conflict_q     <= 1'b0;
      conflict_lit_q <= '0;
      asg_q          <= '0;
      pol_q          <= '0;
`ifdef UCA_STATS_EN
      st_push_q <= '0;
      st_dup_q  <= '0;
      st_null_q <= '0;
`endif
    end else begin
      state_q        <= state_d;
      rr_q           <= rr_d;
      conflict_q     <= conflict_d;
      conflict_lit_q <= conflict_lit_d;
      asg_q          <= asg_d;
      pol_q          <= pol_d;
`ifdef UCA_STATS_EN
      st_push_q <= st_push_d;
      st_dup_q  <= st_dup_d;
      st_null_q <= st_null_d;
`endif
    end
  end

endmodule

// File: tb/tb_uc_arbiter_mc.sv
// tb/tb_uc_arbiter_mc.sv - self-checking bench for uc_arbiter_mc
module tb_uc_arbiter_mc;
  localparam int NE = 4;
  localparam int LW = 9;
  localparam int QS = 4;

  logic          clk = 1'b0;
  logic          rst, clear, mem_valid, mem_done, mem_ready, ucq_valid, ucq_ready, conflict;
  logic [LW-1:0] mem_lit, ucq_lit, conflict_lit;
  logic [NE-1:0] eng_valid, eng_grant;
  logic [NE*LW-1:0] eng_lit;
`ifdef UCA_STATS_EN
  logic [15:0] stat_push, stat_dup, stat_null;
`endif

  uc_arbiter_mc dut (
    .clk(clk), .rst(rst), .clear(clear),
    .mem_valid(mem_valid), .mem_lit(mem_lit), .mem_done(mem_done), .mem_ready(mem_ready),
    .eng_valid(eng_valid), .eng_lit(eng_lit), .eng_grant(eng_grant),
    .ucq_valid(ucq_valid), .ucq_lit(ucq_lit), .ucq_ready(ucq_ready),
    .conflict(conflict), .conflict_lit(conflict_lit)
`ifdef UCA_STATS_EN
    , .stat_push(stat_push), .stat_dup(stat_dup), .stat_null(stat_null)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic clr; logic mv; logic [LW-1:0] ml; logic md;
    logic [NE-1:0] ev; logic [NE*LW-1:0] el; logic rdy;
  } in_t;
  typedef struct packed {
    logic mr; logic [NE-1:0] gr; logic uv; logic [LW-1:0] ul; logic cf; logic [LW-1:0] cl;
  } out_t;
  typedef struct packed { in_t i; out_t o; } vec_t;

  int n_checks = 0;
  int n_err = 0;

  // Reference model: assignment table as arrays, UCQ as a queue, phase flags.
  int mq[$];
  bit m_asg[256];
  bit m_pol[256];
  bit m_arb, m_confl;
  int m_rr, m_clit;
  int m_push, m_dup, m_null;

  vec_t tab[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NE*LW-1:0] pk(input int a, input int b, input int c, input int d);
    return {LW'(d), LW'(c), LW'(b), LW'(a)};
  endfunction

  function automatic int s9(input logic [LW-1:0] x);
    return int'($signed(x));
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int v = 0; v < 256; v++) begin m_asg[v] = 0; m_pol[v] = 0; end
    m_arb = 0; m_confl = 0; m_rr = 0; m_clit = 0;
    m_push = 0; m_dup = 0; m_null = 0;
  endtask

  task automatic model_expect(input in_t in, output out_t o);
    bit full_eff;
    o = '0;
    o.uv = !m_confl && (mq.size() > 0);
    if (o.uv) o.ul = LW'(mq[0]);
    full_eff = (mq.size() == QS) && !(o.uv && in.rdy);
    o.mr = !m_arb && !m_confl && !full_eff;
    if (m_arb && !m_confl && !full_eff) begin
      for (int k = 0; k < NE; k++) begin
        if (o.gr == 0 && in.ev[(m_rr + k) % NE]) o.gr[(m_rr + k) % NE] = 1'b1;
      end
    end
    o.cf = m_confl;
    o.cl = LW'(m_clit);
  endtask

  task automatic model_update(input in_t in, input out_t o);
    bit take;
    int lit, v;
    take = 0; lit = 0;
    if (in.clr) begin
      model_reset();
      return;
    end
    if (o.uv && in.rdy) void'(mq.pop_front());
    if (in.mv && o.mr) begin
      take = 1; lit = s9(in.ml);
    end else begin
      for (int e = 0; e < NE; e++) begin
        if (o.gr[e]) begin
          take = 1; lit = s9(in.el[e*LW +: LW]); m_rr = (e + 1) % NE;
        end
      end
    end
    if (take) begin
      v = (lit < 0) ? -lit : lit;
      if (v < 1 || v > 255) m_null++;
      else if (!m_asg[v]) begin
        m_asg[v] = 1; m_pol[v] = (lit < 0); mq.push_back(lit); m_push++;
      end else if (m_pol[v] == (lit < 0)) m_dup++;
      else begin
        m_confl = 1; m_clit = lit; mq.delete();
      end
    end
    if (!m_arb && !m_confl && in.md) m_arb = 1;
  endtask

  task automatic run_cycle(input in_t in, input bit use_tab, input out_t texp, output logic [NE-1:0] g);
    out_t me, e;
    clear = in.clr; mem_valid = in.mv; mem_lit = in.ml; mem_done = in.md;
    eng_valid = in.ev; eng_lit = in.el; ucq_ready = in.rdy;
    #3;
    model_expect(in, me);
    e = use_tab ? texp : me;
    chk("mem_ready", mem_ready, e.mr);
    chk("eng_grant", eng_grant, e.gr);
    chk("ucq_valid", ucq_valid, e.uv);
    if (e.uv) chk("ucq_lit", ucq_lit, e.ul);
    chk("conflict", conflict, e.cf);
    chk("conflict_lit", conflict_lit, e.cl);
    g = eng_grant;
    model_update(in, me);
    @(posedge clk);
    #1;
  endtask

  task automatic add(input bit clr, input bit mv, input int ml, input bit md, input logic [NE-1:0] ev,
                     input logic [NE*LW-1:0] el, input bit rdy, input bit mr, input logic [NE-1:0] gr,
                     input bit uv, input int ul, input bit cf, input int cl);
    vec_t t;
    t.i = '{clr: clr, mv: mv, ml: LW'(ml), md: md, ev: ev, el: el, rdy: rdy};
    t.o = '{mr: mr, gr: gr, uv: uv, ul: LW'(ul), cf: cf, cl: LW'(cl)};
    tab.push_back(t);
  endtask

  function automatic int rnd_lit();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 0;
    if (r == 1) return -256;
    return ($urandom_range(0, 1) == 1 ? -1 : 1) * int'($urandom_range(1, 8));
  endfunction

  initial begin
    in_t in;
    out_t nox;
    logic [NE-1:0] g;
    int acc;
    logic [NE*LW-1:0] e2;
    nox = '0;
    e2 = pk(2, 4, 3, -2);

    // load 1..5, pop each one cycle after accept
    add(0,1, 1,0,4'h0,'0,1, 1,4'h0,0, 0,0, 0);
    add(0,1, 2,0,4'h0,'0,1, 1,4'h0,1, 1,0, 0);
    add(0,1, 3,0,4'h0,'0,1, 1,4'h0,1, 2,0, 0);
    add(0,1, 4,0,4'h0,'0,1, 1,4'h0,1, 3,0, 0);
    add(0,1, 5,0,4'h0,'0,1, 1,4'h0,1, 4,0, 0);
    add(0,0, 0,1,4'h0,'0,1, 1,4'h0,1, 5,0, 0);
    // engines 2,4,3,-2: three dups then conflict
    add(0,0, 0,0,4'hF,e2,1, 0,4'h1,0, 0,0, 0);
    add(0,0, 0,0,4'hF,e2,1, 0,4'h2,0, 0,0, 0);
    add(0,0, 0,0,4'hF,e2,1, 0,4'h4,0, 0,0, 0);
    add(0,0, 0,0,4'hF,e2,1, 0,4'h8,0, 0,0, 0);
    add(0,0, 0,0,4'hF,e2,1, 0,4'h0,0, 0,1,-2);
    add(0,0, 0,0,4'h0,'0,1, 0,4'h0,0, 0,1,-2);
    // clear out of S_CONFL, then -2 is new
    add(1,0, 0,0,4'h0,'0,1, 0,4'h0,0, 0,1,-2);
    add(0,1,-2,0,4'h0,'0,1, 1,4'h0,0, 0,0, 0);
    add(0,0, 0,0,4'h0,'0,1, 1,4'h0,1,-2,0, 0);
    add(0,0, 0,0,4'h0,'0,1, 1,4'h0,0, 0,0, 0);
    // null literals
    add(0,1, 0,0,4'h0,'0,1, 1,4'h0,0, 0,0, 0);
    add(0,1,-256,0,4'h0,'0,1, 1,4'h0,0, 0,0, 0);
    add(0,0, 0,0,4'h0,'0,1, 1,4'h0,0, 0,0, 0);

    rst = 0; clear = 0; mem_valid = 0; mem_lit = '0; mem_done = 0;
    eng_valid = '0; eng_lit = '0; ucq_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_eng_grant", eng_grant, 0);
    chk("rst_ucq_valid", ucq_valid, 0);
    chk("rst_ucq_lit", ucq_lit, 0);
    chk("rst_conflict", conflict, 0);
    chk("rst_conflict_lit", conflict_lit, 0);
    rst = 1;

    foreach (tab[i]) run_cycle(tab[i].i, 1'b1, tab[i].o, g);
`ifdef UCA_STATS_EN
    chk("stat_null", stat_null, 2);
    chk("stat_push", stat_push, 1);
`endif

    // FIFO fill with consumer stalled, then push+pop at full
    in = '0; in.clr = 1; in.rdy = 1; run_cycle(in, 1'b0, nox, g);
    in = '0; in.md = 1; in.rdy = 1; run_cycle(in, 1'b0, nox, g);
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      in = '0; in.ev = 4'b0001; in.el = pk(10 + acc, 0, 0, 0); in.rdy = 0;
      run_cycle(in, 1'b0, nox, g);
      if (g[0]) acc++;
    end
    chk("ucq_fill_accepts", acc, QS);
    in = '0; in.ev = 4'b0001; in.el = pk(14, 0, 0, 0); in.rdy = 1;
    run_cycle(in, 1'b0, nox, g);
    chk("push_pop_at_full_grant", g, 4'b0001);
    for (int k = 0; k < 5; k++) begin
      in = '0; in.rdy = 1; run_cycle(in, 1'b0, nox, g);
    end

    // fairness between engines 1 and 3
    for (int k = 0; k < 8; k++) begin
      in = '0; in.ev = 4'b1010; in.el = pk(0, 20 + k, 0, 40 + k); in.rdy = 1;
      run_cycle(in, 1'b0, nox, g);
      chk("rr_alternate", g, (k % 2 == 0) ? 4'b0010 : 4'b1000);
    end

    // randomized traffic against the model
    in = '0; in.clr = 1; run_cycle(in, 1'b0, nox, g);
    for (int n = 0; n < 600; n++) begin
      in = '0;
      in.clr = ($urandom_range(0, 39) == 0);
      in.mv = $urandom_range(0, 1) == 1;
      in.ml = LW'(rnd_lit());
      in.md = ($urandom_range(0, 7) == 0);
      in.ev = NE'($urandom_range(0, 15));
      in.el = pk(rnd_lit(), rnd_lit(), rnd_lit(), rnd_lit());
      in.rdy = ($urandom_range(0, 3) != 0);
      run_cycle(in, 1'b0, nox, g);
    end
`ifdef UCA_STATS_EN
    chk("stat_push_rand", stat_push, 16'(m_push));
    chk("stat_dup_rand", stat_dup, 16'(m_dup));
    chk("stat_null_rand", stat_null, 16'(m_null));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
